hub75_scan_driver: RTL and testbench
====================================

Name: hub75_scan_driver

Overview:
- Panel-side scan controller for the 32x16 RGB LED matrix (1/8 scan, top/bottom halves).
- Drives the col_count/row_count that pixel_generator consumes, captures its registered LED_Top/LED_Bottom, and shifts them into the panel.
- Generates the panel shift clock, latch, output enable and row address.
- Sits between pixel_generator and the board pins.

Parameters:
- COLS, 32: columns per row; col_count width = $clog2(COLS).
- ROWS, 8: row pairs (scan lines); row_count/addr width = $clog2(ROWS).
- HALF_PERIOD, 2: sclk half-period in clk cycles; must be >= 1.
- DISPLAY_CYCLES, 256: clk cycles per row in DISPLAY; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run scanning; sampled at row boundaries
- LED_Top  in  3  RGB for the top half, from pixel_generator (valid 1 clk after col_count/row_count)
- LED_Bottom  in  3  RGB for the bottom half, same timing as LED_Top
- col_count  out  5  column request to pixel_generator
- row_count  out  3  row request to pixel_generator
- rgb_top  out  3  panel R1/G1/B1
- rgb_bot  out  3  panel R2/G2/B2
- sclk  out  1  panel shift clock; panel samples on rising edge
- lat  out  1  panel latch, active-high
- oe_n  out  1  panel output enable, active-low
- addr  out  3  panel row address A/B/C
- frame_done  out  1  one-cycle pulse after the last row's DISPLAY

Behaviour:
- Reset (asserted low, async): state=IDLE; every output 0 except oe_n=1. All outputs registered.
  - Reset mid-row aborts immediately: panel blanked, row restarts at 0.
- IDLE: oe_n=1, sclk=0. If enable=1, go to PREFETCH with row_count=0.
- PREFETCH (1 cycle): col_count=0, giving pixel_generator its 1-cycle latency.
- SHIFT: one slot of 2*HALF_PERIOD cycles per column k.
  - Slot cycle 0: rgb_top/rgb_bot <= LED_Top/LED_Bottom; col_count <= k+1 (prefetch; wraps to 0 after COLS-1).
  - sclk=0 for cycles 0..HALF_PERIOD-1, sclk=1 for cycles HALF_PERIOD..2*HALF_PERIOD-1.
  - rgb is stable for the full slot, so setup and hold around the rising edge are each HALF_PERIOD cycles.
  - oe_n=1 throughout SHIFT. After column COLS-1 completes, go to LATCH.
- LATCH (1 cycle): lat=1, sclk=0, oe_n=1, addr <= row_count.
- DISPLAY (DISPLAY_CYCLES cycles): oe_n=0, lat=0, sclk=0.
  - At the end: oe_n=1.
  - If row_count=ROWS-1: row_count wraps to 0 and frame_done pulses for 1 cycle. Otherwise row_count increments.
  - Next state is PREFETCH if enable=1, else IDLE.
- Row period = 1 + COLS*2*HALF_PERIOD + 1 + DISPLAY_CYCLES = 386 clk cycles at the defaults.
- enable deasserted mid-row: the current row finishes (shift, latch, display), then IDLE. No truncated latch ever occurs.
- Rows are shifted while blanked; there is no shift/display overlap.

Optional Feature:
- Macro: HUB75_BRIGHTNESS_EN.
- Defined: adds input brightness [7:0]. It is sampled at LATCH and held for that row. In DISPLAY, oe_n=0 only for the first min(brightness, DISPLAY_CYCLES) cycles, then 1 for the remainder. Row period is unchanged; brightness=0 keeps the panel dark.
- Undefined: port absent; full-duration display.

Decomposition:
- hub75_pkg:
  - state enum (IDLE, PREFETCH, SHIFT, LATCH, DISPLAY)
  - default COLS/ROWS localparams
  - 3-bit colour constants (BLACK=000, RED=100, GREEN=010, BLUE=001, WHITE=111)
- Sub-module hub75_timer: loadable down-counter with a done flag. Shared by slot phase timing and DISPLAY duration.

Test Plan:
- Reset held low with enable=1, then released: all outputs 0, oe_n=1. First sclk rise occurs HALF_PERIOD+1 cycles after leaving IDLE.
- Model pixel_generator (row0=111/111, row2=100/100) and capture 32 bits per row on sclk rise: row 0 all 111, row 2 all 100. The first captured column must equal column 0, not stale data.
- Count sclk rises per row: exactly 32. Exactly one lat pulse per row. addr changes only in the LATCH cycle. oe_n=0 for exactly 256 cycles per row.
- Run 8 rows: addr sequence 0..7. frame_done pulses once, 8*386=3088 cycles after the first PREFETCH. row_count then wraps to 0.
- Drop enable mid-SHIFT of row 3: row 3 still latches and displays, then IDLE with oe_n=1. No further sclk.
- Pulse reset low mid-DISPLAY: oe_n=1 asynchronously; restart scans row 0. With HUB75_BRIGHTNESS_EN and brightness=64: oe_n=0 for 64 of 256 cycles.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared state encoding, default geometry and colour constants for the HUB75 scan driver.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    SHIFT,
    LATCH,
    DISPLAY
  } state_t;

  localparam int DEFAULT_COLS = 32;
  localparam int DEFAULT_ROWS = 8;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] WHITE = 3'b111;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hub75_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module hub75_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         done
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 1/8-scan driver: prefetches pixels, shifts a row out blanked, latches it, then displays it.
// Build option HUB75_BRIGHTNESS_EN adds a brightness input that limits the oe_n window per row.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int COLS           = DEFAULT_COLS,
  parameter int ROWS           = DEFAULT_ROWS,
  parameter int HALF_PERIOD    = 2,
  parameter int DISPLAY_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]              brightness,
`endif
  input  logic [2:0]              LED_Top,
  input  logic [2:0]              LED_Bottom,
  output logic [$clog2(COLS)-1:0] col_count,
  output logic [$clog2(ROWS)-1:0] row_count,
  output logic [2:0]              rgb_top,
  output logic [2:0]              rgb_bot,
  output logic                    sclk,
  output logic                    lat,
  output logic                    oe_n,
  output logic [$clog2(ROWS)-1:0] addr,
  output logic                    frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(max_int(DISPLAY_CYCLES, 2 * HALF_PERIOD)) + 1;

  localparam logic [TW-1:0] SLOT_LAST = TW'(2 * HALF_PERIOD - 1);
  localparam logic [TW-1:0] HALF      = TW'(HALF_PERIOD);
  localparam logic [TW-1:0] DISP_LAST = TW'(DISPLAY_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   col_idx_reg, col_idx_next;
  logic [CW-1:0]   col_count_reg, col_count_next;
  logic [RW-1:0]   row_count_reg, row_count_next;
  logic [2:0]      rgb_top_reg, rgb_top_next;
  logic [2:0]      rgb_bot_reg, rgb_bot_next;
  logic            sclk_reg, sclk_next;
  logic            lat_reg, lat_next;
  logic            oe_n_reg, oe_n_next;
  logic [RW-1:0]   addr_reg, addr_next;
  logic            frame_done_reg, frame_done_next;

  logic            timer_load;
  logic [TW-1:0]   timer_value;
  logic [TW-1:0]   timer_count;
  logic            timer_done;

  // first_dark: oe_n for the first DISPLAY cycle; next_dark: oe_n for the following cycle.
  logic            first_dark;
  logic            next_dark;

  hub75_timer #(
    .W(TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .count (timer_count),
    .done  (timer_done)
  );

`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0] bright_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bright_reg <= '0;
    end else if (state_reg == LATCH) begin
      bright_reg <= brightness;
    end
  end

  // Timer holds DISPLAY_CYCLES-1-i during display cycle i, so the next index is DISPLAY_CYCLES-count.
  assign first_dark = (brightness == 8'd0);
  assign next_dark  = ((DISPLAY_CYCLES - int'(timer_count)) >= int'(bright_reg));
`else
  assign first_dark = 1'b0;
  assign next_dark  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      col_idx_reg    <= '0;
      col_count_reg  <= '0;
      row_count_reg  <= '0;
      rgb_top_reg    <= BLACK;
      rgb_bot_reg    <= BLACK;
      sclk_reg       <= 1'b0;
      lat_reg        <= 1'b0;
      oe_n_reg       <= 1'b1;
      addr_reg       <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_idx_reg    <= col_idx_next;
      col_count_reg  <= col_count_next;
      row_count_reg  <= row_count_next;
      rgb_top_reg    <= rgb_top_next;
      rgb_bot_reg    <= rgb_bot_next;
      sclk_reg       <= sclk_next;
      lat_reg        <= lat_next;
      oe_n_reg       <= oe_n_next;
      addr_reg       <= addr_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    col_idx_next    = col_idx_reg;
    col_count_next  = col_count_reg;
    row_count_next  = row_count_reg;
    rgb_top_next    = rgb_top_reg;
    rgb_bot_next    = rgb_bot_reg;
    sclk_next       = 1'b0;
    lat_next        = 1'b0;
    oe_n_next       = 1'b1;
    addr_next       = addr_reg;
    frame_done_next = 1'b0;
    timer_load      = 1'b0;
    timer_value     = '0;

    unique case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next     = PREFETCH;
          row_count_next = '0;
          col_count_next = '0;
        end
      end

      PREFETCH: begin
        state_next   = SHIFT;
        col_idx_next = '0;
        timer_load   = 1'b1;
        timer_value  = SLOT_LAST;
      end

      SHIFT: begin
        // Timer runs SLOT_LAST..0 across a slot; sclk is registered for the upcoming slot cycle.
        sclk_next = (timer_count <= HALF);
        if (timer_count == SLOT_LAST) begin
          rgb_top_next   = LED_Top;
          rgb_bot_next   = LED_Bottom;
          col_count_next = (col_idx_reg == COL_LAST) ? '0 : col_idx_reg + CW'(1);
        end
        if (timer_done) begin
          sclk_next = 1'b0;
          if (col_idx_reg == COL_LAST) begin
            state_next = LATCH;
            lat_next   = 1'b1;
            addr_next  = row_count_reg;
          end else begin
            col_idx_next = col_idx_reg + CW'(1);
            timer_load   = 1'b1;
            timer_value  = SLOT_LAST;
          end
        end
      end

      LATCH: begin
        state_next  = DISPLAY;
        oe_n_next   = first_dark;
        timer_load  = 1'b1;
        timer_value = DISP_LAST;
      end

      DISPLAY: begin
        if (timer_done) begin
          oe_n_next      = 1'b1;
          col_count_next = '0;
          if (row_count_reg == ROW_LAST) begin
            row_count_next  = '0;
            frame_done_next = 1'b1;
          end else begin
            row_count_next = row_count_reg + RW'(1);
          end
          state_next = enable ? PREFETCH : IDLE;
        end else begin
          oe_n_next = next_dark;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign col_count  = col_count_reg;
  assign row_count  = row_count_reg;
  assign rgb_top    = rgb_top_reg;
  assign rgb_bot    = rgb_bot_reg;
  assign sclk       = sclk_reg;
  assign lat        = lat_reg;
  assign oe_n       = oe_n_reg;
  assign addr       = addr_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: timing vector table, pixel/latch scoreboard and reset/enable corner cases.
module tb_hub75_scan_driver;
  import hub75_pkg::*;

  localparam int COLS   = 32;
  localparam int DISP   = 256;
  localparam int ROWP   = 386;
`ifdef HUB75_BRIGHTNESS_EN
  localparam int EXP_ON = 64;
`else
  localparam int EXP_ON = DISP;
`endif

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] led_top;
  logic [2:0] led_bot;
  logic [4:0] col_count;
  logic [2:0] row_count;
  logic [2:0] rgb_top;
  logic [2:0] rgb_bot;
  logic       sclk;
  logic       lat;
  logic       oe_n;
  logic [2:0] addr;
  logic       frame_done;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0] brightness;
  initial brightness = 8'(EXP_ON);
`endif

  hub75_scan_driver dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .LED_Top    (led_top),
    .LED_Bottom (led_bot),
    .col_count  (col_count),
    .row_count  (row_count),
    .rgb_top    (rgb_top),
    .rgb_bot    (rgb_bot),
    .sclk       (sclk),
    .lat        (lat),
    .oe_n       (oe_n),
    .addr       (addr),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Pixel source: rows 0 and 2 are solid colours, the others vary by column.
  function automatic logic [5:0] pix(input int r, input int c);
    logic [2:0]  t;
    logic [2:0]  b;
    logic [31:0] cv;
    cv = c;
    case (r)
      0:       begin t = WHITE; b = WHITE; end
      1:       begin t = cv[0] ? BLUE : GREEN; b = BLACK; end
      2:       begin t = RED; b = RED; end
      default: begin t = cv[2:0] ^ 3'(r); b = cv[4:2]; end
    endcase
    return {t, b};
  endfunction

  initial begin
    led_top = BLACK;
    led_bot = BLACK;
  end

  always @(posedge clk) begin
    {led_top, led_bot} <= pix(int'(row_count), int'(col_count));
  end

  typedef struct {
    int         row;
    int         col;
    logic [2:0] top;
    logic [2:0] bot;
  } pix_t;

  pix_t       pix_q[$];
  logic [2:0] lat_q[$];

  task automatic push_row(input int r);
    logic [5:0] p;
    pix_t       e;
    for (int c = 0; c < COLS; c++) begin
      p = pix(r, c);
      e.row = r;
      e.col = c;
      e.top = p[5:3];
      e.bot = p[2:0];
      pix_q.push_back(e);
    end
    lat_q.push_back(3'(r));
  endtask

  // Monitor: captures on sclk rise, checks latch address, rises per row and oe_n window.
  int         rises = 0;
  int         oe_run = 0;
  int         fd_count = 0;
  logic       sclk_q = 1'b0;
  logic       oe_q = 1'b1;
  logic [2:0] addr_q = 3'd0;

  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rises  = 0;
        oe_run = 0;
      end else begin
        if (sclk && !sclk_q) begin
          rises++;
          if (pix_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sclk_rise: got an unexpected rise, required no shifting");
          end else begin
            e = pix_q.pop_front();
            chk($sformatf("pixel r%0d c%0d", e.row, e.col), 32'({rgb_top, rgb_bot}), 32'({e.top, e.bot}));
          end
        end
        if (lat) begin
          chk("sclk_rises_per_row", rises, COLS);
          rises = 0;
          if (lat_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL lat_pulse: got an unexpected latch, required none");
          end else begin
            chk("latch_addr", 32'(addr), 32'(lat_q.pop_front()));
          end
        end
        if (addr != addr_q) chk("addr_changes_only_in_latch", 32'(lat), 32'd1);
        if (!oe_n) begin
          oe_run++;
        end else if (!oe_q) begin
          chk("oe_low_cycles", oe_run, EXP_ON);
          oe_run = 0;
        end
        if (frame_done) fd_count++;
      end
      sclk_q = sclk;
      oe_q   = oe_n;
      addr_q = addr;
    end
  end

  typedef struct {
    int         cyc;
    logic       sclk;
    logic       lat;
    logic       oe_n;
    logic [2:0] addr;
    logic [4:0] col;
    logic [2:0] row;
    logic       fd;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int cyc, input logic s, input logic l, input logic o,
                         input int a, input int cc, input int r, input logic f);
    vec_t v;
    v.cyc  = cyc;
    v.sclk = s;
    v.lat  = l;
    v.oe_n = o;
    v.addr = 3'(a);
    v.col  = 5'(cc);
    v.row  = 3'(r);
    v.fd   = f;
    vecs.push_back(v);
  endtask

  initial begin
    int found;
    logic oe_end;
    oe_end = (EXP_ON < DISP);

    // Cycle 0 is the PREFETCH that follows reset release; fields: sclk lat oe_n addr col row fd.
    add_vec(0,    0, 0, 1,             0, 0,  0, 0);
    add_vec(1,    0, 0, 1,             0, 0,  0, 0);
    add_vec(2,    0, 0, 1,             0, 1,  0, 0);
    add_vec(3,    1, 0, 1,             0, 1,  0, 0);
    add_vec(4,    1, 0, 1,             0, 1,  0, 0);
    add_vec(5,    0, 0, 1,             0, 1,  0, 0);
    add_vec(6,    0, 0, 1,             0, 2,  0, 0);
    add_vec(125,  0, 0, 1,             0, 31, 0, 0);
    add_vec(126,  0, 0, 1,             0, 0,  0, 0);
    add_vec(128,  1, 0, 1,             0, 0,  0, 0);
    add_vec(129,  0, 1, 1,             0, 0,  0, 0);
    add_vec(130,  0, 0, (EXP_ON == 0), 0, 0,  0, 0);
    if (EXP_ON > 0) add_vec(129 + EXP_ON, 0, 0, 0, 0, 0, 0, 0);
    add_vec(130 + EXP_ON, 0, 0, 1, 0, 0, (130 + EXP_ON >= ROWP) ? 1 : 0, 0);
    add_vec(386,  0, 0, 1,             0, 0,  1, 0);
    add_vec(389,  1, 0, 1,             0, 1,  1, 0);
    add_vec(515,  0, 1, 1,             1, 0,  1, 0);
    add_vec(3087, 0, 0, oe_end,        7, 0,  7, 0);
    add_vec(3088, 0, 0, 1,             7, 0,  0, 1);
    add_vec(3089, 0, 0, 1,             7, 0,  0, 0);
    add_vec(4375, 0, 1, 1,             3, 0,  3, 0);
    add_vec(4631, 0, 0, oe_end,        3, 0,  3, 0);
    add_vec(4632, 0, 0, 1,             3, 0,  4, 0);
    add_vec(5200, 0, 0, 1,             3, 0,  4, 0);

    reset  = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_outputs",
        32'({sclk, lat, oe_n, addr, col_count, row_count, rgb_top, rgb_bot, frame_done}),
        32'({1'b0, 1'b0, 1'b1, 3'd0, 5'd0, 3'd0, 3'd0, 3'd0, 1'b0}));

    // One full frame, then rows 0..3 of the next frame before enable is dropped.
    for (int r = 0; r < 8; r++) push_row(r);
    for (int r = 0; r < 4; r++) push_row(r);
    reset = 1'b1;

    for (int c = 0; c <= 5200; c++) begin
      @(negedge clk);
      if (c == 4300) enable = 1'b0;  // mid-SHIFT of row 3 in the second frame
      foreach (vecs[i]) begin
        if (vecs[i].cyc == c) begin
          chk($sformatf("vec%0d cycle %0d", i, c),
              32'({sclk, lat, oe_n, addr, col_count, row_count, frame_done}),
              32'({vecs[i].sclk, vecs[i].lat, vecs[i].oe_n, vecs[i].addr,
                   vecs[i].col, vecs[i].row, vecs[i].fd}));
        end
      end
    end
    chk("pixels_left_after_frames", pix_q.size(), 0);
    chk("latches_left_after_frames", lat_q.size(), 0);
    chk("frame_done_pulses", fd_count, 1);

    // Reset pulse in the middle of row 0's display window.
    push_row(0);
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge clk);
      if (!oe_n) found = 1;
    end
    chk("reached_display", found, 1);
    repeat (EXP_ON / 2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_oe_n", 32'(oe_n), 32'd1);
    chk("async_reset_outputs", 32'({sclk, lat, row_count, addr, col_count}), 32'd0);
    repeat (3) @(negedge clk);
    push_row(0);
    reset = 1'b1;
    @(negedge clk);
    chk("restart_row0_prefetch", 32'({row_count, col_count, oe_n}), 32'({3'd0, 5'd0, 1'b1}));
    for (int i = 0; i < 400 && lat_q.size() != 0; i++) @(negedge clk);
    chk("restart_latched", lat_q.size(), 0);
    enable = 1'b0;
    repeat (400) @(negedge clk);
    chk("idle_after_restart", 32'({oe_n, sclk, lat, row_count}), 32'({1'b1, 1'b0, 1'b0, 3'd1}));
    chk("pixels_left_after_restart", pix_q.size(), 0);
    chk("frame_done_pulses_final", fd_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
